// File: rtl/cache_pkg.sv
// Shared definitions for the N-way write-back cache: controller states and
// the fixed address/block geometry of the block memory interface.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    ALLOCATE
  } state_t;

  // Word offset inside a block (4 x 32-bit words).
  localparam int unsigned OFF_W = 2;
  // Block width of the memory side.
  localparam int unsigned BLK_W = 128;

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim selection for one set.
// Ports:
//   age_in  : current per-way ages of the set, way w at [w*AW +: AW]
//   acc_way : way being accessed this cycle
//   valid   : per-way valid bits of the set
//   age_out : ages after an access to acc_way
//   victim  : lowest-index invalid way, else the way whose age is WAYS-1
module cache_lru #(
  parameter int unsigned WAYS = 2
) (
  input  logic [WAYS*$clog2(WAYS)-1:0] age_in,
  input  logic [$clog2(WAYS)-1:0]      acc_way,
  input  logic [WAYS-1:0]              valid,
  output logic [WAYS*$clog2(WAYS)-1:0] age_out,
  output logic [$clog2(WAYS)-1:0]      victim
);

  localparam int unsigned AW = $clog2(WAYS);

  logic [AW-1:0] acc_age;
  logic          found;

  always_comb begin
    acc_age = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (acc_way == AW'(w)) acc_age = age_in[w*AW +: AW];
    end

    age_out = age_in;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (acc_way == AW'(w))
        age_out[w*AW +: AW] = '0;
      else if (age_in[w*AW +: AW] < acc_age)
        age_out[w*AW +: AW] = age_in[w*AW +: AW] + 1'b1;
    end
  end

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = AW'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_in[w*AW +: AW] == AW'(WAYS - 1)) victim = AW'(w);
      end
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with true-LRU
// replacement and hit/miss counters.
// Ports:
//   clk, proc_reset         : clock (rising edge), async active-high reset
//   proc_read/proc_write    : processor request, held while proc_stall is high
//   proc_addr/proc_wdata    : word address {tag, index, offset} and write data
//   proc_stall/proc_rdata   : access not complete / read data of hitting line
//   mem_read/mem_write      : block refill / write-back request
//   mem_addr/mem_wdata      : block address and write-back block
//   mem_rdata/mem_ready     : refill block and request completion strobe
//   hit_cnt/miss_cnt        : wrapping performance counters
module cache_nway
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 4,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned TAG_W = 28 - IDX_W
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);

  localparam int unsigned AW    = $clog2(WAYS);
  localparam int unsigned WORDS = 1 << OFF_W;

  logic                   valid_q [SETS][WAYS];
  logic                   dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]       tag_q   [SETS][WAYS];
  logic [BLK_W-1:0]       data_q  [SETS][WAYS];
  logic [WAYS*AW-1:0]     age_q   [SETS];

  state_t                 state_q, state_d;
  logic [AW-1:0]          victim_q;
  logic                   refilled_q;

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [OFF_W-1:0]       off;
  logic                   req;
  logic                   hit;
  logic [AW-1:0]          hit_way;
  logic [WAYS-1:0]        valid_vec;
  logic [WAYS*AW-1:0]     age_next;
  logic [AW-1:0]          lru_victim;
  logic [BLK_W-1:0]       hit_line;
  logic                   complete;
  logic                   miss_evt;
  logic                   fill_en;
  logic                   wb_done;

  assign idx = proc_addr[IDX_W+OFF_W-1:OFF_W];
  assign tag = proc_addr[29:IDX_W+OFF_W];
  assign off = proc_addr[OFF_W-1:0];
  assign req = proc_read | proc_write;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      valid_vec[w] = valid_q[idx][w];
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  cache_lru #(.WAYS(WAYS)) u_lru (
    .age_in  (age_q[idx]),
    .acc_way (hit_way),
    .valid   (valid_vec),
    .age_out (age_next),
    .victim  (lru_victim)
  );

  always_comb begin
    hit_line   = data_q[idx][hit_way];
    proc_rdata = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (off == OFF_W'(k)) proc_rdata = hit_line[k*32 +: 32];
    end
  end

  assign proc_stall = (req & ~hit) | (state_q != IDLE);
  assign fill_en    = (state_q == ALLOCATE) && mem_ready;
  assign wb_done    = (state_q == WRITE_BACK) && mem_ready;

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    complete  = 1'b0;
    miss_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            complete = 1'b1;
          end else begin
            miss_evt = 1'b1;
            state_d  = (valid_q[idx][lru_victim] && dirty_q[idx][lru_victim])
                       ? WRITE_BACK : ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        mem_write = 1'b1;
        mem_addr  = {tag_q[idx][victim_q], idx};
        mem_wdata = data_q[idx][victim_q];
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = proc_addr[29:OFF_W];
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w]          <= 1'b0;
          dirty_q[s][w]          <= 1'b0;
          age_q[s][w*AW +: AW]   <= AW'(w);
        end
      end
      victim_q   <= '0;
      refilled_q <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      // Marks the completion cycle right after a refill so it is not
      // counted as a hit on top of the miss already recorded.
      refilled_q <= fill_en;
      if (miss_evt) begin
        miss_cnt <= miss_cnt + 32'd1;
        victim_q <= lru_victim;
      end
      if (complete) begin
        age_q[idx] <= age_next;
        if (!refilled_q) hit_cnt <= hit_cnt + 32'd1;
        if (proc_write) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (wb_done) dirty_q[idx][victim_q] <= 1'b0;
      if (fill_en) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data payload carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx][victim_q] <= mem_rdata;
      tag_q[idx][victim_q]  <= tag;
    end else if (complete && proc_write) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        if (off == OFF_W'(k)) data_q[idx][hit_way][k*32 +: 32] <= proc_wdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
module tb_cache_nway;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int checks = 0;
  int fails  = 0;

  bit           use_ovr = 1'b0;
  logic [127:0] fill_ovr = '0;

  always #5 clk = ~clk;

  cache_nway #(.WAYS(4), .SETS(4)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  // Backing memory content: every word holds its own word address.
  function automatic logic [127:0] fill_of(input logic [29:0] a);
    logic [29:0] b;
    b = {a[29:2], 2'b00};
    return {2'b00, b + 30'd3, 2'b00, b + 30'd2, 2'b00, b + 30'd1, 2'b00, b};
  endfunction

  task automatic do_reset;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    mem_ready  = 1'b0;
    proc_reset = 1'b1;
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
  endtask

  // Drives one access to completion, acting as the block memory.
  task automatic access(input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                        input int lw, input int lr,
                        output logic [31:0] rd, output int stalls, output int nwb, output int nal,
                        output logic [27:0] wb_addr, output logic [127:0] wb_data,
                        output logic [27:0] al_addr);
    bit done;
    stalls = 0; nwb = 0; nal = 0; rd = '0; done = 1'b0;
    wb_addr = '0; wb_data = '0; al_addr = '0;
    @(negedge clk);
    proc_read  = ~wr;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wd;
    for (int guard = 0; guard < 40 && !done; guard++) begin
      #1;
      mem_ready = 1'b0;
      checks++;
      if (mem_read && mem_write) begin
        fails++;
        $display("FAIL mem_exclusive: mem_read=%b mem_write=%b, required not both", mem_read, mem_write);
      end
      if (!proc_stall) begin
        rd   = proc_rdata;
        done = 1'b1;
      end else begin
        stalls++;
        if (mem_write) begin
          if (nwb == 0) begin wb_addr = mem_addr; wb_data = mem_wdata; end
          nwb++;
          mem_ready = (nwb == lw);
        end else if (mem_read) begin
          if (nal == 0) al_addr = mem_addr;
          nal++;
          mem_rdata = use_ovr ? fill_ovr : fill_of({mem_addr, 2'b00});
          mem_ready = (nal == lr);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL access_timeout: addr=%h still stalled, required completion", addr);
    end else begin
      @(posedge clk);
    end
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    mem_ready  = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if (proc_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b, required 0", proc_stall); end
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin fails++; $display("FAIL reset_memctl: got %b, required 00", {mem_read, mem_write}); end
    checks++;
    if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin fails++; $display("FAIL reset_membus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata); end
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin fails++; $display("FAIL reset_counters: hit=%0d miss=%0d, required 0 0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_read_miss;
    logic [31:0] rd; int st, nw, na; logic [27:0] wa, aa; logic [127:0] wdt;
    use_ovr  = 1'b1;
    fill_ovr = 128'h44444444_33333333_22222222_11111111;
    access(1'b0, 30'h10, 32'h0, 1, 2, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 3) begin fails++; $display("FAIL miss_stalls: got %0d, required 3", st); end
    checks++;
    if (na !== 2 || aa !== 28'h4) begin fails++; $display("FAIL miss_alloc: cycles=%0d addr=%h, required 2 4", na, aa); end
    checks++;
    if (nw !== 0) begin fails++; $display("FAIL miss_no_wb: got %0d write cycles, required 0", nw); end
    checks++;
    if (rd !== 32'h11111111) begin fails++; $display("FAIL miss_rdata: got %h, required 11111111", rd); end
    checks++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin fails++; $display("FAIL miss_counters: hit=%0d miss=%0d, required 0 1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_read_hit;
    logic [31:0] rd; int st, nw, na; logic [27:0] wa, aa; logic [127:0] wdt;
    access(1'b0, 30'h10, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 0 || rd !== 32'h11111111) begin fails++; $display("FAIL hit_word0: stalls=%0d data=%h, required 0 11111111", st, rd); end
    checks++;
    if (hit_cnt !== 32'd1) begin fails++; $display("FAIL hit_cnt1: got %0d, required 1", hit_cnt); end
    access(1'b0, 30'h13, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 0 || rd !== 32'h44444444) begin fails++; $display("FAIL hit_word3: stalls=%0d data=%h, required 0 44444444", st, rd); end
    checks++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin fails++; $display("FAIL hit_counters: hit=%0d miss=%0d, required 2 1", hit_cnt, miss_cnt); end
    use_ovr = 1'b0;
  endtask

  task automatic test_lru;
    logic [31:0] rd; int st, nw, na; logic [27:0] wa, aa; logic [127:0] wdt;
    logic [29:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 30'(i * 16);
      access(1'b0, a, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
      checks++;
      if (st !== 2 || rd !== {2'b00, a}) begin fails++; $display("FAIL lru_fill%0d: stalls=%0d data=%h, required 2 %h", i, st, rd, a); end
    end
    access(1'b0, 30'h00, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    access(1'b0, 30'h20, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 0) begin fails++; $display("FAIL lru_touch_hit: stalls=%0d, required 0", st); end
    access(1'b0, 30'h40, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 2 || nw !== 0 || rd !== 32'h40) begin fails++; $display("FAIL lru_tag4: stalls=%0d wb=%0d data=%h, required 2 0 40", st, nw, rd); end
    for (int i = 0; i < 4; i++) begin
      a = (i == 1) ? 30'h40 : 30'(i * 16);
      access(1'b0, a, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
      checks++;
      if (st !== 0 || rd !== {2'b00, a}) begin fails++; $display("FAIL lru_resident%0d: stalls=%0d data=%h, required 0 %h", i, st, rd, a); end
    end
    access(1'b0, 30'h10, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 2) begin fails++; $display("FAIL lru_tag1_evicted: stalls=%0d, required 2", st); end
    checks++;
    if (miss_cnt !== 32'd6 || hit_cnt !== 32'd6) begin fails++; $display("FAIL lru_counters: hit=%0d miss=%0d, required 6 6", hit_cnt, miss_cnt); end
  endtask

  task automatic test_writeback;
    logic [31:0] rd; int st, nw, na; logic [27:0] wa, aa; logic [127:0] wdt;
    do_reset();
    for (int i = 0; i < 4; i++) access(1'b0, 30'(i * 16), 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    access(1'b1, 30'h01, 32'hDEADBEEF, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 0) begin fails++; $display("FAIL wb_write_hit: stalls=%0d, required 0", st); end
    for (int i = 1; i < 4; i++) access(1'b0, 30'(i * 16), 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    access(1'b0, 30'h40, 32'h0, 1, 2, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 4) begin fails++; $display("FAIL wb_stalls: got %0d, required 4", st); end
    checks++;
    if (nw !== 1 || wa !== 28'h0) begin fails++; $display("FAIL wb_addr: cycles=%0d addr=%h, required 1 0", nw, wa); end
    checks++;
    if (wdt !== 128'h00000003_00000002_DEADBEEF_00000000) begin fails++; $display("FAIL wb_data: got %h, required 00000003_00000002_deadbeef_00000000", wdt); end
    checks++;
    if (na !== 2 || aa !== 28'h10 || rd !== 32'h40) begin fails++; $display("FAIL wb_alloc: cycles=%0d addr=%h data=%h, required 2 10 40", na, aa, rd); end
    checks++;
    if (miss_cnt !== 32'd5 || hit_cnt !== 32'd4) begin fails++; $display("FAIL wb_counters: hit=%0d miss=%0d, required 4 5", hit_cnt, miss_cnt); end
  endtask

  task automatic test_write_miss;
    logic [31:0] rd; int st, nw, na; logic [27:0] wa, aa; logic [127:0] wdt;
    do_reset();
    access(1'b1, 30'h3, 32'hCAFEF00D, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 2 || nw !== 0 || aa !== 28'h0) begin fails++; $display("FAIL wmiss_alloc: stalls=%0d wb=%0d addr=%h, required 2 0 0", st, nw, aa); end
    access(1'b0, 30'h3, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 0 || rd !== 32'hCAFEF00D) begin fails++; $display("FAIL wmiss_readback: stalls=%0d data=%h, required 0 cafef00d", st, rd); end
    access(1'b0, 30'h2, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (rd !== 32'h2) begin fails++; $display("FAIL wmiss_other_word: got %h, required 2", rd); end
    for (int i = 1; i < 4; i++) access(1'b0, 30'(i * 16), 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    access(1'b0, 30'h40, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (nw !== 1 || wa !== 28'h0) begin fails++; $display("FAIL wmiss_dirty_evict: cycles=%0d addr=%h, required 1 0", nw, wa); end
    checks++;
    if (wdt !== 128'hCAFEF00D_00000002_00000001_00000000) begin fails++; $display("FAIL wmiss_wb_data: got %h, required cafef00d_00000002_00000001_00000000", wdt); end
    checks++;
    if (miss_cnt !== 32'd5 || hit_cnt !== 32'd2) begin fails++; $display("FAIL wmiss_counters: hit=%0d miss=%0d, required 2 5", hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int st, nw, na; logic [27:0] wa, aa; logic [127:0] wdt;
    do_reset();
    access(1'b0, 30'h10, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h20;
    #1;
    checks++;
    if (proc_stall !== 1'b1) begin fails++; $display("FAIL mid_detect: stall=%b, required 1", proc_stall); end
    @(negedge clk);
    #1;
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h8) begin fails++; $display("FAIL mid_alloc: mem_read=%b addr=%h, required 1 8", mem_read, mem_addr); end
    proc_reset = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 28'h0) begin fails++; $display("FAIL mid_abort: rd=%b wr=%b addr=%h, required 0 0 0", mem_read, mem_write, mem_addr); end
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin fails++; $display("FAIL mid_counters: hit=%0d miss=%0d, required 0 0", hit_cnt, miss_cnt); end
    proc_read = 1'b0;
    #1;
    checks++;
    if (proc_stall !== 1'b0) begin fails++; $display("FAIL mid_idle: stall=%b, required 0", proc_stall); end
    @(negedge clk);
    proc_reset = 1'b0;
    access(1'b0, 30'h10, 32'h0, 1, 1, rd, st, nw, na, wa, wdt, aa);
    checks++;
    if (st !== 2 || miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin fails++; $display("FAIL mid_contents_lost: stalls=%0d miss=%0d hit=%0d, required 2 1 0", st, miss_cnt, hit_cnt); end
  endtask

  initial begin
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_lru();
    test_writeback();
    test_write_miss();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
